ddr_lattice_unpacker: RTL and testbench
=======================================

// Module: ddr_lattice_unpacker
// PURPOSE
//  AXI-Stream sink that unpacks one lattice node per beat (Q distribution directions, DATA_WIDTH each) from
//  the DDR DMA into Q parallel BRAM write lanes. It sits between the DMA MM2S stream and the lattice BRAM
//  bank, and is the parametrised successor of the fixed D2Q9 pixel unpacker.
//  Adds registered outputs, credit gating against the consumer, frame accounting and TLAST checking with
//  resynchronisation.
// PARAMETERS
//  DATA_WIDTH     16    bits per direction lane
//  Q              9     directions per node (D2Q9=9, D3Q19=19)
//  DEPTH          2500  nodes per frame = BRAM depth
//  ADDRESS_WIDTH  12    BRAM address width; must satisfy 2**ADDRESS_WIDTH >= DEPTH+1
//  FCNT_WIDTH     16    frame counter width
// PORTS
//  m00_axis_aclk    in   1               clock
//  m00_axis_areset  in   1               asynchronous reset, active high
//  enable           in   1               start/continue accepting frames
//  clear_err        in   1               clear sticky error flags
//  rd_limit         in   ADDRESS_WIDTH   nodes the consumer has released (0..DEPTH); write allowed while ptr < rd_limit
//  m00_axis_tvalid  in   1               stream valid
//  m00_axis_tdata   in   Q*DATA_WIDTH    lane k = tdata[k*DATA_WIDTH +: DATA_WIDTH], k=0 is the N direction
//  m00_axis_tlast   in   1               last node of frame
//  m00_axis_tready  out  1               stream ready
//  dir_data         out  Q*DATA_WIDTH    registered lane data to the BRAMs, same lane order as tdata
//  wen              out  1               BRAM write enable, all lanes
//  write_addr       out  ADDRESS_WIDTH   BRAM address for dir_data
//  frame_done       out  1               1-cycle pulse: a well-formed frame was written
//  frame_count      out  FCNT_WIDTH      completed well-formed frames; wraps modulo 2**FCNT_WIDTH
//  err_early_tlast  out  1               sticky: TLAST arrived before node DEPTH-1
//  err_missing_tlast out 1               sticky: node DEPTH-1 arrived without TLAST
// BEHAVIOUR
//  Reset: state=IDLE, ptr=0, all outputs 0 (tready, wen, dir_data, write_addr, frame_done, frame_count, errs).
//  Accept = tvalid & tready. tready is combinational from state, ptr and rd_limit only (never from tvalid):
//   IDLE: 0. RUN: enable & (ptr < rd_limit). FLUSH: 1 (discard mode).
//  Latency 1: a beat accepted in cycle k gives wen=1, dir_data=tdata and write_addr=ptr(k) in cycle k+1.
//   wen=0 in every cycle with no accept in RUN. FLUSH beats never assert wen.
//  FSM:
//   IDLE  -> RUN when enable=1 (ptr=0).
//   RUN, accept, ptr<DEPTH-1, !tlast: ptr+=1.
//   RUN, accept, ptr==DEPTH-1, tlast: write; ptr=0; frame_done=1 next cycle; frame_count+=1.
//   RUN, accept, ptr<DEPTH-1, tlast: write; ptr=0; err_early_tlast=1; no frame_done/count.
//   RUN, accept, ptr==DEPTH-1, !tlast: write; ptr=0; err_missing_tlast=1; -> FLUSH.
//   FLUSH, accept with tlast: -> RUN with ptr=0 (that beat is discarded); otherwise stay.
//   RUN with enable=0: tready=0 and state is held (mid-frame pause, ptr kept). Return to IDLE only via reset.
//  Credit: rd_limit is sampled each cycle. With ptr==rd_limit the block stalls, without a bubble once the
//   limit rises. rd_limit>DEPTH is treated as DEPTH.
//  clear_err clears both flags. If clear_err and a new error occur in the same cycle, the error wins (flag=1).
//  Reset mid-frame: immediate return to the reset state, and any partial frame is abandoned.
//  Arithmetic: ptr and the compare are unsigned ADDRESS_WIDTH. frame_count wraps without saturation.
// TESTING
//  T1 DEPTH=8,Q=9,rd_limit=8,enable: 8 beats, tlast on 8th -> wen at addr 0..7 one cycle after each accept,
//     lane3 = tdata[63:48], frame_done pulses once, frame_count=1.
//  T2 rd_limit=3, then raised to 8 at cycle 10: tready drops after 3 accepts (addr 0..2), and the next accept
//     comes in the cycle rd_limit=8 is seen.
//  T3 tlast on 5th beat: err_early_tlast=1, frame_count unchanged, and the next beat writes addr 0.
//  T4 8 beats, no tlast, then 3 more beats with tlast on the 3rd: err_missing_tlast=1, the 3 beats have no wen,
//     and the following frame writes from addr 0.
//  T5 tvalid toggling randomly, enable pulsed low mid-frame: wen count equals the accept count, addresses are
//     contiguous, and nothing is accepted while enable=0.
//  T6 assert reset at beat 4 of a frame, then a full frame: all outputs 0 during reset; the next frame writes
//     addr 0..7 with frame_count=1. clear_err coincident with an error leaves the flag at 1.

Source files
------------

// File: rtl/ddr_lattice_unpacker.sv
// ddr_lattice_unpacker
//   AXI-Stream sink that takes one lattice node per beat (Q directions of DATA_WIDTH bits) from the
//   DMA MM2S stream and writes it to Q parallel BRAM lanes. Outputs are registered one cycle behind
//   the accepting beat. Writes are gated by a consumer credit (rd_limit). The block counts complete
//   frames, flags malformed frames, and resynchronises to the next TLAST after a missing TLAST.
//
// Ports
//   m00_axis_aclk     in   clock
//   m00_axis_areset   in   asynchronous reset, active high
//   enable            in   start/continue accepting frames
//   clear_err         in   clear sticky error flags
//   rd_limit          in   nodes released by the consumer; write allowed while ptr < rd_limit
//   m00_axis_tvalid   in   stream valid
//   m00_axis_tdata    in   lane k = tdata[k*DATA_WIDTH +: DATA_WIDTH], lane 0 is N
//   m00_axis_tlast    in   last node of frame
//   m00_axis_tready   out  stream ready (never depends on tvalid)
//   dir_data          out  registered lane data, same lane order as tdata
//   wen               out  BRAM write enable, all lanes
//   write_addr        out  BRAM address for dir_data
//   frame_done        out  1-cycle pulse after a well-formed frame was written
//   frame_count       out  completed well-formed frames, wraps
//   err_early_tlast   out  sticky: TLAST before the last node
//   err_missing_tlast out  sticky: last node without TLAST
module ddr_lattice_unpacker #(
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned Q             = 9,
  parameter int unsigned DEPTH         = 2500,
  parameter int unsigned ADDRESS_WIDTH = 12,
  parameter int unsigned FCNT_WIDTH    = 16
) (
  input  logic                         m00_axis_aclk,
  input  logic                         m00_axis_areset,
  input  logic                         enable,
  input  logic                         clear_err,
  input  logic [ADDRESS_WIDTH-1:0]     rd_limit,
  input  logic                         m00_axis_tvalid,
  input  logic [Q*DATA_WIDTH-1:0]      m00_axis_tdata,
  input  logic                         m00_axis_tlast,
  output logic                         m00_axis_tready,
  output logic [Q*DATA_WIDTH-1:0]      dir_data,
  output logic                         wen,
  output logic [ADDRESS_WIDTH-1:0]     write_addr,
  output logic                         frame_done,
  output logic [FCNT_WIDTH-1:0]        frame_count,
  output logic                         err_early_tlast,
  output logic                         err_missing_tlast
);

  localparam logic [ADDRESS_WIDTH-1:0] LpDepth = ADDRESS_WIDTH'(DEPTH);
  localparam logic [ADDRESS_WIDTH-1:0] LpLast  = ADDRESS_WIDTH'(DEPTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StFlush} state_e;

  state_e                       r_state, w_state_next;
  logic [ADDRESS_WIDTH-1:0]     r_ptr, w_ptr_next;
  logic [ADDRESS_WIDTH-1:0]     w_limit;
  logic                         w_ready;
  logic                         w_accept;
  logic                         w_wen_next;
  logic                         w_done_next;
  logic                         w_set_early;
  logic                         w_set_missing;

  logic [Q*DATA_WIDTH-1:0]      r_dir_data;
  logic                         r_wen;
  logic [ADDRESS_WIDTH-1:0]     r_write_addr;
  logic                         r_frame_done;
  logic [FCNT_WIDTH-1:0]        r_frame_count;
  logic                         r_err_early;
  logic                         r_err_missing;

  // Credit clamp: a consumer reporting more than a frame's worth is treated as a full frame.
  always_comb begin
    w_limit = (rd_limit > LpDepth) ? LpDepth : rd_limit;
  end

  // Ready depends only on state, ptr and the credit, so the upstream may wait on it safely.
  always_comb begin
    w_ready = 1'b0;
    unique case (r_state)
      StIdle:  w_ready = 1'b0;
      StRun:   w_ready = enable & (r_ptr < w_limit);
      StFlush: w_ready = 1'b1;
      default: w_ready = 1'b0;
    endcase
  end

  assign w_accept        = m00_axis_tvalid & w_ready;
  assign m00_axis_tready = w_ready;

  always_comb begin
    w_state_next  = r_state;
    w_ptr_next    = r_ptr;
    w_wen_next    = 1'b0;
    w_done_next   = 1'b0;
    w_set_early   = 1'b0;
    w_set_missing = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (enable) begin
          w_state_next = StRun;
          w_ptr_next   = '0;
        end
      end
      StRun: begin
        if (w_accept) begin
          w_wen_next = 1'b1;
          if (r_ptr == LpLast) begin
            w_ptr_next = '0;
            if (m00_axis_tlast) begin
              w_done_next = 1'b1;
            end else begin
              // Lost frame alignment: discard until the upstream's own TLAST.
              w_set_missing = 1'b1;
              w_state_next  = StFlush;
            end
          end else if (m00_axis_tlast) begin
            w_ptr_next  = '0;
            w_set_early = 1'b1;
          end else begin
            w_ptr_next = r_ptr + ADDRESS_WIDTH'(1);
          end
        end
      end
      StFlush: begin
        if (w_accept && m00_axis_tlast) begin
          w_state_next = StRun;
          w_ptr_next   = '0;
        end
      end
      default: begin
        w_state_next = StIdle;
        w_ptr_next   = '0;
      end
    endcase
  end

  always_ff @(posedge m00_axis_aclk or posedge m00_axis_areset) begin
    if (m00_axis_areset) begin
      r_state <= StIdle;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_next;
      r_ptr   <= w_ptr_next;
    end
  end

  always_ff @(posedge m00_axis_aclk or posedge m00_axis_areset) begin
    if (m00_axis_areset) begin
      r_dir_data    <= '0;
      r_wen         <= 1'b0;
      r_write_addr  <= '0;
      r_frame_done  <= 1'b0;
      r_frame_count <= '0;
      r_err_early   <= 1'b0;
      r_err_missing <= 1'b0;
    end else begin
      r_wen        <= w_wen_next;
      r_frame_done <= w_done_next;
      if (w_wen_next) begin
        r_dir_data   <= m00_axis_tdata;
        r_write_addr <= r_ptr;
      end
      if (w_done_next) begin
        r_frame_count <= r_frame_count + FCNT_WIDTH'(1);
      end
      // A new error in the same cycle as clear_err must stay visible.
      if (w_set_early) begin
        r_err_early <= 1'b1;
      end else if (clear_err) begin
        r_err_early <= 1'b0;
      end
      if (w_set_missing) begin
        r_err_missing <= 1'b1;
      end else if (clear_err) begin
        r_err_missing <= 1'b0;
      end
    end
  end

  assign dir_data          = r_dir_data;
  assign wen               = r_wen;
  assign write_addr        = r_write_addr;
  assign frame_done        = r_frame_done;
  assign frame_count       = r_frame_count;
  assign err_early_tlast   = r_err_early;
  assign err_missing_tlast = r_err_missing;

endmodule

// File: tb/tb_ddr_lattice_unpacker.sv
// Bench for ddr_lattice_unpacker with DEPTH=8, Q=9, DATA_WIDTH=16.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_ddr_lattice_unpacker;

  localparam int DW    = 16;
  localparam int Q     = 9;
  localparam int DEPTH = 8;
  localparam int AW    = 4;
  localparam int FW    = 16;
  localparam int QW    = Q * DW;

  localparam int MIdle  = 0;
  localparam int MRun   = 1;
  localparam int MFlush = 2;

  logic          clk;
  logic          rst;
  logic          enable;
  logic          clear_err;
  logic [AW-1:0] rd_limit;
  logic          tvalid;
  logic [QW-1:0] tdata;
  logic          tlast;
  logic          tready;
  logic [QW-1:0] dir_data;
  logic          wen;
  logic [AW-1:0] write_addr;
  logic          frame_done;
  logic [FW-1:0] frame_count;
  logic          err_early_tlast;
  logic          err_missing_tlast;

  ddr_lattice_unpacker #(
    .DATA_WIDTH    (DW),
    .Q             (Q),
    .DEPTH         (DEPTH),
    .ADDRESS_WIDTH (AW),
    .FCNT_WIDTH    (FW)
  ) u_dut (
    .m00_axis_aclk     (clk),
    .m00_axis_areset   (rst),
    .enable            (enable),
    .clear_err         (clear_err),
    .rd_limit          (rd_limit),
    .m00_axis_tvalid   (tvalid),
    .m00_axis_tdata    (tdata),
    .m00_axis_tlast    (tlast),
    .m00_axis_tready   (tready),
    .dir_data          (dir_data),
    .wen               (wen),
    .write_addr        (write_addr),
    .frame_done        (frame_done),
    .frame_count       (frame_count),
    .err_early_tlast   (err_early_tlast),
    .err_missing_tlast (err_missing_tlast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: frame position plus the registered outputs expected next.
  int            m_mode;
  int            m_node;
  bit            m_acc;
  logic          e_wen;
  logic [AW-1:0] e_addr;
  logic [QW-1:0] e_data;
  logic          e_done;
  logic [FW-1:0] e_count;
  logic          e_early;
  logic          e_missing;
  int            obs_wen;
  int            obs_done;
  int            n_run_acc;

  typedef struct {
    bit            v;
    logic [AW-1:0] lim;
    bit            rdy;
    bit            wen;
    int            addr;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [QW-1:0] act, input logic [QW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [QW-1:0] mk(input int b);
    logic [QW-1:0] d;
    d = '0;
    for (int k = 0; k < Q; k++) d[k*DW +: DW] = {8'(k), 8'(b)};
    return d;
  endfunction

  function automatic logic [QW-1:0] rand_data();
    logic [QW-1:0] d;
    d = '0;
    for (int k = 0; k < Q; k++) d[k*DW +: DW] = 16'($urandom);
    return d;
  endfunction

  task automatic model_reset();
    m_mode    = MIdle;
    m_node    = 0;
    m_acc     = 1'b0;
    e_wen     = 1'b0;
    e_addr    = '0;
    e_data    = '0;
    e_done    = 1'b0;
    e_count   = '0;
    e_early   = 1'b0;
    e_missing = 1'b0;
  endtask

  // One clock: compare at the falling edge, advance the model, return 1 unit after the rising edge.
  task automatic step(input bit tb, input bit t_rdy, input bit t_wen, input int t_addr);
    bit exp_rdy;
    int lim;
    @(negedge clk);
    lim = (int'(rd_limit) > DEPTH) ? DEPTH : int'(rd_limit);
    case (m_mode)
      MIdle:   exp_rdy = 1'b0;
      MRun:    exp_rdy = enable && (m_node < lim);
      default: exp_rdy = 1'b1;
    endcase
    check("tready", tready, exp_rdy);
    check("wen", wen, e_wen);
    if (e_wen) begin
      check("write_addr", write_addr, e_addr);
      check("dir_data", dir_data, e_data);
    end
    check("frame_done", frame_done, e_done);
    check("frame_count", frame_count, e_count);
    check("err_early_tlast", err_early_tlast, e_early);
    check("err_missing_tlast", err_missing_tlast, e_missing);
    if (tb) begin
      check("tbl_tready", tready, t_rdy);
      check("tbl_wen", wen, t_wen);
      if (t_wen) begin
        check("tbl_addr", write_addr, AW'(t_addr));
        check("tbl_lane3", dir_data[63:48], {8'd3, 8'(t_addr)});
      end
    end
    if (wen) obs_wen++;
    if (frame_done) obs_done++;

    m_acc  = tvalid && exp_rdy;
    e_wen  = 1'b0;
    e_done = 1'b0;
    if (clear_err) begin
      e_early   = 1'b0;
      e_missing = 1'b0;
    end
    case (m_mode)
      MIdle: begin
        if (enable) begin
          m_mode = MRun;
          m_node = 0;
        end
      end
      MRun: begin
        if (m_acc) begin
          n_run_acc++;
          e_wen  = 1'b1;
          e_addr = AW'(m_node);
          e_data = tdata;
          if (m_node == DEPTH - 1) begin
            m_node = 0;
            if (tlast) begin
              e_done  = 1'b1;
              e_count = e_count + 1'b1;
            end else begin
              e_missing = 1'b1;
              m_mode    = MFlush;
            end
          end else if (tlast) begin
            m_node  = 0;
            e_early = 1'b1;
          end else begin
            m_node++;
          end
        end
      end
      default: begin
        if (m_acc && tlast) begin
          m_mode = MRun;
          m_node = 0;
        end
      end
    endcase
    @(posedge clk);
    #1;
  endtask

  task automatic step0();
    step(1'b0, 1'b0, 1'b0, 0);
  endtask

  // Present one beat and hold it until accepted (bounded).
  task automatic send_beat(input bit last, input bit clr);
    int k;
    k = 0;
    tvalid    = 1'b1;
    tlast     = last;
    tdata     = rand_data();
    clear_err = clr;
    do begin
      step0();
      k++;
    end while (!m_acc && k < 40);
    check("beat_accepted", m_acc, 1'b1);
    tvalid    = 1'b0;
    tlast     = 1'b0;
    clear_err = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #2;
    check("rst_tready", tready, 0);
    check("rst_wen", wen, 0);
    check("rst_dir_data", dir_data, 0);
    check("rst_write_addr", write_addr, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_frame_count", frame_count, 0);
    check("rst_err_early", err_early_tlast, 0);
    check("rst_err_missing", err_missing_tlast, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_hold_wen", wen, 0);
    check("rst_hold_tready", tready, 0);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int bidx;
    rst       = 1'b0;
    enable    = 1'b0;
    clear_err = 1'b0;
    rd_limit  = '0;
    tvalid    = 1'b0;
    tdata     = '0;
    tlast     = 1'b0;
    obs_wen   = 0;
    obs_done  = 0;
    n_run_acc = 0;
    model_reset();
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    enable   = 1'b1;
    rd_limit = 4'd8;
    apply_reset();

    // T1 (rows 0-10) then T2 credit stall at 3, raised to 8 ten cycles in (rows 11-26).
    tbl.push_back('{1'b1, 4'd8, 1'b0, 1'b0, 0});
    tbl.push_back('{1'b1, 4'd8, 1'b1, 1'b0, 0});
    tbl.push_back('{1'b1, 4'd8, 1'b1, 1'b1, 0});
    tbl.push_back('{1'b1, 4'd8, 1'b1, 1'b1, 1});
    tbl.push_back('{1'b1, 4'd8, 1'b1, 1'b1, 2});
    tbl.push_back('{1'b1, 4'd8, 1'b1, 1'b1, 3});
    tbl.push_back('{1'b1, 4'd8, 1'b1, 1'b1, 4});
    tbl.push_back('{1'b1, 4'd8, 1'b1, 1'b1, 5});
    tbl.push_back('{1'b1, 4'd8, 1'b1, 1'b1, 6});
    tbl.push_back('{1'b0, 4'd8, 1'b1, 1'b1, 7});
    tbl.push_back('{1'b0, 4'd8, 1'b1, 1'b0, 0});
    tbl.push_back('{1'b1, 4'd3, 1'b1, 1'b0, 0});
    tbl.push_back('{1'b1, 4'd3, 1'b1, 1'b1, 0});
    tbl.push_back('{1'b1, 4'd3, 1'b1, 1'b1, 1});
    tbl.push_back('{1'b1, 4'd3, 1'b0, 1'b1, 2});
    for (int i = 0; i < 6; i++) tbl.push_back('{1'b1, 4'd3, 1'b0, 1'b0, 0});
    tbl.push_back('{1'b1, 4'd8, 1'b1, 1'b0, 0});
    tbl.push_back('{1'b1, 4'd8, 1'b1, 1'b1, 3});
    tbl.push_back('{1'b1, 4'd8, 1'b1, 1'b1, 4});
    tbl.push_back('{1'b1, 4'd8, 1'b1, 1'b1, 5});
    tbl.push_back('{1'b1, 4'd8, 1'b1, 1'b1, 6});
    tbl.push_back('{1'b0, 4'd8, 1'b1, 1'b1, 7});

    bidx     = 0;
    obs_done = 0;
    for (int i = 0; i < tbl.size(); i++) begin
      tvalid   = tbl[i].v;
      rd_limit = tbl[i].lim;
      tdata    = tbl[i].v ? mk(bidx) : '0;
      tlast    = tbl[i].v && (bidx == DEPTH - 1);
      step(1'b1, tbl[i].rdy, tbl[i].wen, tbl[i].addr);
      if (tbl[i].v && tbl[i].rdy) bidx = (bidx == DEPTH - 1) ? 0 : bidx + 1;
      if (i == 10) begin
        check("t1_done_pulses", obs_done, 1);
        check("t1_frame_count", frame_count, 1);
      end
    end
    tvalid = 1'b0;
    tlast  = 1'b0;
    check("t2_frame_count", frame_count, 2);

    // T3: early TLAST on the 5th beat.
    for (int b = 0; b < 5; b++) send_beat(b == 4, 1'b0);
    check("t3_err_early", err_early_tlast, 1);
    check("t3_count_held", frame_count, 2);
    send_beat(1'b0, 1'b0);
    check("t3_restart_wen", wen, 1);
    check("t3_restart_addr", write_addr, 0);
    for (int b = 1; b < 8; b++) send_beat(b == 7, 1'b0);
    step0();
    check("t3_count", frame_count, 3);

    // T4: clear, then missing TLAST and a 3-beat discard.
    clear_err = 1'b1;
    step0();
    clear_err = 1'b0;
    check("t4_clear", err_early_tlast, 0);
    for (int b = 0; b < 8; b++) send_beat(1'b0, 1'b0);
    check("t4_err_missing", err_missing_tlast, 1);
    step0();
    obs_wen = 0;
    for (int b = 0; b < 3; b++) send_beat(b == 2, 1'b0);
    step0();
    check("t4_flush_no_wen", obs_wen, 0);
    send_beat(1'b0, 1'b0);
    check("t4_restart_wen", wen, 1);
    check("t4_restart_addr", write_addr, 0);
    for (int b = 1; b < 8; b++) send_beat(b == 7, 1'b0);
    check("t4_count", frame_count, 4);
    step0();

    // T5: random valid, credit, TLAST and clears, with two enable-low windows.
    obs_wen   = 0;
    n_run_acc = 0;
    for (int c = 0; c < 300; c++) begin
      enable   = !((c >= 60 && c < 80) || (c >= 200 && c < 210));
      tvalid   = 1'($urandom_range(0, 1));
      rd_limit = 4'($urandom_range(0, 15));
      if (m_mode == MFlush) tlast = ($urandom_range(0, 3) == 0);
      else if (m_node == DEPTH - 1) tlast = ($urandom_range(0, 7) != 0);
      else tlast = ($urandom_range(0, 15) == 0);
      tdata     = rand_data();
      clear_err = ($urandom_range(0, 31) == 0);
      step0();
    end
    tvalid    = 1'b0;
    tlast     = 1'b0;
    clear_err = 1'b0;
    enable    = 1'b1;
    rd_limit  = 4'd8;
    step0();
    step0();
    check("t5_wen_vs_accepts", obs_wen, n_run_acc);

    // T6: reset while beat 4 is on the bus, then a clean frame.
    apply_reset();
    for (int b = 0; b < 3; b++) send_beat(1'b0, 1'b0);
    tvalid = 1'b1;
    tdata  = rand_data();
    tlast  = 1'b0;
    apply_reset();
    tvalid = 1'b0;
    send_beat(1'b0, 1'b0);
    check("t6_first_addr", write_addr, 0);
    for (int b = 1; b < 8; b++) send_beat(b == 7, 1'b0);
    step0();
    check("t6_count", frame_count, 1);
    // clear_err in the same cycle as a new early-TLAST error.
    for (int b = 0; b < 3; b++) send_beat(b == 2, b == 2);
    check("t6_clear_vs_error", err_early_tlast, 1);
    step0();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
